// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Covers state encoding, the latched request fields and the list popcount.
package ldm_stm_sequencer_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_N      = 16;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned WORD_BYTES = 4;

   localparam logic [IDX_W-1:0] PC_IDX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_WB   = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   // Request fields still needed after the Start cycle.
   typedef struct packed {
      logic              is_load;
      logic              u;
      logic [IDX_W-1:0]  base_idx;
      logic [DATA_W-1:0] base;
   } xfer_req_t;

   function automatic logic [CNT_W-1:0] popcount16(input logic [REG_N-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(REG_N); i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Pipeline-facing port bundle of the sequencer: request, register file and memory sides.
interface ldm_stm_sequencer_if;
   import ldm_stm_sequencer_pkg::*;

   logic              Start;
   logic              IsLoad;
   logic              P;
   logic              U;
   logic              W;
   logic [REG_N-1:0]  RegList;
   logic [IDX_W-1:0]  BaseIdx;
   logic [DATA_W-1:0] Base;
   logic [DATA_W-1:0] MemRD;
   logic [DATA_W-1:0] RegRD;

   logic              Busy;
   logic [IDX_W-1:0]  RegIdx;
   logic              RegWE;
   logic [DATA_W-1:0] RegWD;
   logic              PCLoad;
   logic [DATA_W-1:0] PCData;
   logic [DATA_W-1:0] MemAddr;
   logic              MemWE;
   logic [DATA_W-1:0] MemWD;
   logic              Done;

   modport slave (
      input  Start, IsLoad, P, U, W, RegList, BaseIdx, Base, MemRD, RegRD,
      output Busy, RegIdx, RegWE, RegWD, PCLoad, PCData, MemAddr, MemWE, MemWD, Done
   );

   modport master (
      output Start, IsLoad, P, U, W, RegList, BaseIdx, Base, MemRD, RegRD,
      input  Busy, RegIdx, RegWE, RegWD, PCLoad, PCData, MemAddr, MemWE, MemWD, Done
   );

endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Combinational 16-bit priority encoder: index of the lowest set bit plus valid.
module ldm_stm_sequencer_lowest_set_bit
   import ldm_stm_sequencer_pkg::*;
(
   input  logic [REG_N-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = int'(REG_N) - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

   assign valid = |vec;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: walks RegList one register per cycle,
// then optionally writes back the updated base register.
module ldm_stm_sequencer
   import ldm_stm_sequencer_pkg::*;
(
   input  logic                 CLK,
   input  logic                 Reset,
   ldm_stm_sequencer_if.slave   bus
);

   localparam logic [DATA_W-1:0] WORD = DATA_W'(WORD_BYTES);

   seq_state_t        state;
   xfer_req_t         req_q;
   logic [CNT_W-1:0]  n_q;
   logic              wb_en_q;
   logic [REG_N-1:0]  remaining_q;

   logic              busy_q;
   logic [IDX_W-1:0]  reg_idx_q;
   logic              reg_we_q;
   logic              pc_load_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_addr_q;
   logic              done_q;

   logic [REG_N-1:0]  lsb_vec;
   logic [IDX_W-1:0]  lsb_idx;
   logic              lsb_valid;
   logic [REG_N-1:0]  lsb_onehot;
   logic [CNT_W-1:0]  n_c;
   logic [DATA_W-1:0] nbytes_c;
   logic [DATA_W-1:0] start_addr_c;
   logic [DATA_W-1:0] nbytes_q;
   logic [DATA_W-1:0] wb_value;
   logic              wb_en_c;

   // One encoder serves both the fresh list at Start and the working copy.
   assign lsb_vec = (state == ST_IDLE) ? bus.RegList : remaining_q;

   ldm_stm_sequencer_lowest_set_bit lowest_set_bit (
      .vec   (lsb_vec),
      .idx   (lsb_idx),
      .valid (lsb_valid)
   );

   assign lsb_onehot = REG_N'(1) << lsb_idx;
   assign n_c        = popcount16(bus.RegList);
   assign nbytes_c   = DATA_W'(n_c) * WORD;
   assign wb_en_c    = bus.W && !(bus.IsLoad && bus.RegList[bus.BaseIdx]);

   always_comb begin
      start_addr_c = bus.Base;
      case ({bus.P, bus.U})
         2'b01:   start_addr_c = bus.Base;
         2'b11:   start_addr_c = bus.Base + WORD;
         2'b00:   start_addr_c = bus.Base - nbytes_c + WORD;
         default: start_addr_c = bus.Base - nbytes_c;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         req_q       <= '0;
         n_q         <= '0;
         wb_en_q     <= 1'b0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         reg_idx_q   <= '0;
         reg_we_q    <= 1'b0;
         pc_load_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         busy_q     <= 1'b0;
         reg_idx_q  <= '0;
         reg_we_q   <= 1'b0;
         pc_load_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         done_q     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.Start) begin
                  req_q   <= '{is_load: bus.IsLoad, u: bus.U,
                               base_idx: bus.BaseIdx, base: bus.Base};
                  n_q     <= n_c;
                  wb_en_q <= wb_en_c;
                  if (lsb_valid) begin
                     state       <= ST_XFER;
                     busy_q      <= 1'b1;
                     reg_idx_q   <= lsb_idx;
                     mem_addr_q  <= start_addr_c;
                     mem_we_q    <= !bus.IsLoad;
                     reg_we_q    <= bus.IsLoad && (lsb_idx != PC_IDX);
                     pc_load_q   <= bus.IsLoad && (lsb_idx == PC_IDX);
                     remaining_q <= lsb_vec & ~lsb_onehot;
                  end else begin
                     state  <= ST_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            ST_XFER: begin
               if (lsb_valid) begin
                  busy_q      <= 1'b1;
                  reg_idx_q   <= lsb_idx;
                  mem_addr_q  <= mem_addr_q + WORD;
                  mem_we_q    <= !req_q.is_load;
                  reg_we_q    <= req_q.is_load && (lsb_idx != PC_IDX);
                  pc_load_q   <= req_q.is_load && (lsb_idx == PC_IDX);
                  remaining_q <= lsb_vec & ~lsb_onehot;
               end else if (wb_en_q) begin
                  state     <= ST_WB;
                  busy_q    <= 1'b1;
                  reg_idx_q <= req_q.base_idx;
                  reg_we_q  <= 1'b1;
               end else begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_WB: begin
               state  <= ST_DONE;
               done_q <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign nbytes_q = DATA_W'(n_q) * WORD;
   assign wb_value = req_q.u ? (req_q.base + nbytes_q) : (req_q.base - nbytes_q);

   // Data paths pass through in the same cycle as the registered address/index.
   assign bus.RegWD  = !reg_we_q ? '0 : (state == ST_WB) ? wb_value : bus.MemRD;
   assign bus.PCData = pc_load_q ? bus.MemRD : '0;
   assign bus.MemWD  = !mem_we_q ? '0 :
                       (reg_idx_q == req_q.base_idx) ? req_q.base : bus.RegRD;

   assign bus.Busy    = busy_q;
   assign bus.RegIdx  = reg_idx_q;
   assign bus.RegWE   = reg_we_q;
   assign bus.PCLoad  = pc_load_q;
   assign bus.MemWE   = mem_we_q;
   assign bus.MemAddr = mem_addr_q;
   assign bus.Done    = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with simple memory and register-file models.
module tb_ldm_stm_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   ldm_stm_sequencer_if bus();

   ldm_stm_sequencer dut (
      .CLK   (clk),
      .Reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns a tag of the address; register file returns a tag of the index.
   always_comb bus.MemRD = {16'hD00D, bus.MemAddr[15:0]};
   always_comb bus.RegRD = 32'hA000_0000 | 32'(bus.RegIdx);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Control flags packed as {Busy, Done, RegWE, MemWE, PCLoad}.
   task automatic check_ctl(input string tag, input logic [4:0] exp);
      check(tag, 32'({bus.Busy, bus.Done, bus.RegWE, bus.MemWE, bus.PCLoad}), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic ld, input logic p, input logic u, input logic w,
                             input logic [15:0] list, input logic [3:0] bidx,
                             input logic [31:0] base);
      bus.Start   = 1'b1;
      bus.IsLoad  = ld;
      bus.P       = p;
      bus.U       = u;
      bus.W       = w;
      bus.RegList = list;
      bus.BaseIdx = bidx;
      bus.Base    = base;
      tick();
      bus.Start   = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.Start = 1'b0; bus.IsLoad = 1'b0; bus.P = 1'b0; bus.U = 1'b0; bus.W = 1'b0;
      bus.RegList = '0; bus.BaseIdx = '0; bus.Base = '0;
      #12;
      check_ctl("reset_ctl", 5'b00000);
      check("reset_addr", bus.MemAddr, 32'h0);
      check("reset_idx", 32'(bus.RegIdx), 32'h0);
      reset = 1'b0;
      tick();

      // STM R0,R2,R3 from 0x100 increment-after with writeback.
      start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 16'h000D, 4'd13, 32'h100);
      check_ctl("stm1_c1_ctl", 5'b10010);
      check("stm1_c1_idx", 32'(bus.RegIdx), 32'd0);
      check("stm1_c1_addr", bus.MemAddr, 32'h100);
      check("stm1_c1_wd", bus.MemWD, 32'hA000_0000);
      tick();
      check("stm1_c2_idx", 32'(bus.RegIdx), 32'd2);
      check("stm1_c2_addr", bus.MemAddr, 32'h104);
      check("stm1_c2_wd", bus.MemWD, 32'hA000_0002);
      tick();
      check("stm1_c3_idx", 32'(bus.RegIdx), 32'd3);
      check("stm1_c3_addr", bus.MemAddr, 32'h108);
      tick();
      check_ctl("stm1_wb_ctl", 5'b10100);
      check("stm1_wb_idx", 32'(bus.RegIdx), 32'd13);
      check("stm1_wb_wd", bus.RegWD, 32'h10C);
      check("stm1_wb_memwd", bus.MemWD, 32'h0);
      tick();
      check_ctl("stm1_done_ctl", 5'b01000);
      tick();
      check_ctl("stm1_idle_ctl", 5'b00000);

      // LDM R0,R1,PC decrement-before, no writeback.
      start_xfer(1'b1, 1'b1, 1'b0, 1'b0, 16'h8003, 4'd5, 32'h200);
      check_ctl("ldm2_c1_ctl", 5'b10100);
      check("ldm2_c1_addr", bus.MemAddr, 32'h1F4);
      check("ldm2_c1_wd", bus.RegWD, 32'hD00D_01F4);
      tick();
      check("ldm2_c2_idx", 32'(bus.RegIdx), 32'd1);
      check("ldm2_c2_addr", bus.MemAddr, 32'h1F8);
      tick();
      check_ctl("ldm2_c3_ctl", 5'b10001);
      check("ldm2_c3_idx", 32'(bus.RegIdx), 32'd15);
      check("ldm2_c3_pc", bus.PCData, 32'hD00D_01FC);
      check("ldm2_c3_regwd", bus.RegWD, 32'h0);
      tick();
      check_ctl("ldm2_done_ctl", 5'b01000);
      tick();

      // LDM of the base register with W=1: loaded value wins, writeback skipped.
      start_xfer(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 4'd4, 32'h300);
      check_ctl("ldm3_c1_ctl", 5'b10100);
      check("ldm3_c1_idx", 32'(bus.RegIdx), 32'd4);
      check("ldm3_c1_wd", bus.RegWD, 32'hD00D_0300);
      tick();
      check_ctl("ldm3_done_ctl", 5'b01000);
      tick();

      // Empty list: Done right away, no bus activity.
      start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd2, 32'h400);
      check_ctl("empty_done_ctl", 5'b01000);
      check("empty_addr", bus.MemAddr, 32'h0);
      tick();
      check_ctl("empty_idle_ctl", 5'b00000);

      // Reset on the second transfer cycle of an 8-register STM.
      start_xfer(1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 4'd9, 32'h500);
      tick();
      check("rst_c2_addr", bus.MemAddr, 32'h504);
      #2 reset = 1'b1;
      #1;
      check_ctl("rst_async_ctl", 5'b00000);
      check("rst_async_addr", bus.MemAddr, 32'h0);
      check("rst_async_wd", bus.MemWD, 32'h0);
      check("rst_async_idx", 32'(bus.RegIdx), 32'h0);
      #1 reset = 1'b0;
      tick();
      check_ctl("rst_noresume_ctl", 5'b00000);
      start_xfer(1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 4'd9, 32'h600);
      check_ctl("fresh_c1_ctl", 5'b10010);
      check("fresh_c1_idx", 32'(bus.RegIdx), 32'd1);
      check("fresh_c1_addr", bus.MemAddr, 32'h604);
      tick();
      check_ctl("fresh_done_ctl", 5'b01000);
      tick();

      // STM with base in list, decrement-after; a second Start mid-transfer is ignored.
      start_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 4'd5, 32'h1000);
      check("busy6_c1_idx", 32'(bus.RegIdx), 32'd4);
      check("busy6_c1_addr", bus.MemAddr, 32'hFFC);
      check("busy6_c1_wd", bus.MemWD, 32'hA000_0004);
      start_xfer(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 4'd0, 32'h0);
      check_ctl("busy6_c2_ctl", 5'b10010);
      check("busy6_c2_idx", 32'(bus.RegIdx), 32'd5);
      check("busy6_c2_addr", bus.MemAddr, 32'h1000);
      check("busy6_c2_wd", bus.MemWD, 32'h1000);
      tick();
      check_ctl("busy6_wb_ctl", 5'b10100);
      check("busy6_wb_idx", 32'(bus.RegIdx), 32'd5);
      check("busy6_wb_wd", bus.RegWD, 32'hFF8);
      tick();
      check_ctl("busy6_done_ctl", 5'b01000);
      tick();
      check_ctl("busy6_idle_ctl", 5'b00000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  clock; all state updates on posedge.
REQ-002 SHALL have port Reset  input  1  reset Reset, asynchronous, active-high.
REQ-003 SHALL have port Start  input  1  one-cycle request to begin a block transfer.
REQ-004 SHALL have port IsLoad  input  1  1 = LDM (memory to registers), 0 = STM.
REQ-005 SHALL have ports P, U, W  input  1 each  pre-index, up, base-writeback bits.
REQ-006 SHALL have port RegList  input  16  register list; bit i selects Ri.
REQ-007 SHALL have port BaseIdx  input  4  base register index.
REQ-008 SHALL have port Base  input  32  base register value.
REQ-009 SHALL have port MemRD  input  32  memory read data, valid in the same cycle as MemAddr.
REQ-010 SHALL have port RegRD  input  32  register file read data for RegIdx.
REQ-011 SHALL have port Busy  output  1  sequencer owns register ports; the pipeline stalls.
REQ-012 SHALL have port RegIdx  output  4  register index, used as register read/write index.
REQ-013 SHALL have ports RegWE, RegWD  output  1/32  register file write enable and data.
REQ-014 SHALL have ports PCLoad, PCData  output  1/32  R15 load request and value.
REQ-015 SHALL have ports MemAddr, MemWE, MemWD  output  32/1/32  data memory address, write enable, write data.
REQ-016 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, XFER, WB, DONE.
REQ-018 In IDLE with Start=1, SHALL latch all inputs, compute N = popcount(RegList), and go to XFER if N>0, else to DONE.
REQ-019 SHALL ignore Start in any state other than IDLE.
REQ-020 SHALL set the start address to Base (P=0,U=1), Base+4 (P=1,U=1), Base-4N+4 (P=0,U=0), or Base-4N (P=1,U=0), all modulo 2^32.
REQ-021 In XFER, SHALL transfer one register per cycle in ascending index order, with the address incrementing by 4 each cycle.
REQ-022 In XFER, SHALL drive RegIdx to the lowest remaining set bit, then clear that bit in its working copy.
REQ-023 On STM in XFER, SHALL drive MemWE=1 and MemWD=RegRD, with RegWE=0.
REQ-024 On LDM in XFER for index<15, SHALL drive RegWE=1 and RegWD=MemRD.
REQ-025 On LDM in XFER for index 15, SHALL drive PCLoad=1 and PCData=MemRD, with RegWE=0.
REQ-026 After the last XFER cycle, SHALL go to WB if W=1 and not (IsLoad and RegList[BaseIdx]); otherwise it SHALL go to DONE.
REQ-027 In WB, SHALL drive RegWE=1, RegIdx=BaseIdx, and RegWD=Base+4N (U=1) or Base-4N (U=0), computed from the latched Base.
REQ-028 In WB, SHALL hold MemWE=0.
REQ-029 On STM with the base register in the list, SHALL store the original latched Base value.
REQ-030 SHALL drive Busy=1 in XFER and WB, and Busy=0 in IDLE and DONE.
REQ-031 SHALL drive Done=1 only in DONE.
REQ-032 DONE SHALL always return to IDLE on the next cycle.
REQ-033 Latency SHALL be N + (1 if WB) + 1 cycles from Start to Done.
REQ-034 Outside XFER and WB, SHALL drive RegWE, MemWE, PCLoad = 0 and all data/address outputs = 0.

Reset
REQ-035 Reset=1 SHALL force IDLE and clear all outputs and latched registers to 0 immediately, including mid-transfer.
REQ-036 After reset is released, an in-progress transfer SHALL NOT resume.

Structure
REQ-037 A shared package SHALL hold the state encodings (2-bit), WORD_BYTES=4, and the R15 index constant.
REQ-038 SHALL instantiate one sub-module, lowest_set_bit: a combinational 16-bit priority encoder returning index and valid.
REQ-039 Popcount SHALL be computed combinationally at Start.

Verification
REQ-040 STM, P=0, U=1, W=1, Base=0x100, RegList=0x000D -> stores R0, R2, R3 at 0x100, 0x104, 0x108; WB writes 0x10C; Done in cycle 5.
REQ-041 LDM, P=1, U=0, W=0, Base=0x200, RegList=0x8003 -> reads 0x1F4, 0x1F8, 0x1FC into R0, R1, then PC (PCLoad in cycle 3); no WB.
REQ-042 LDM, W=1, BaseIdx=4, RegList=0x0010 -> R4 gets the loaded value; WB is skipped.
REQ-043 RegList=0 -> Done one cycle after Start; no writes; Busy stays 0.
REQ-044 Reset asserted on the second XFER cycle of an 8-register STM -> outputs are 0 at once; the next Start begins a fresh transfer.
REQ-045 Start pulsed while Busy=1 -> ignored; the current transfer completes unchanged.
